exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt initiator that sits at the MEM (commit) stage and drives the exception side of the CP0 register file.
- Gathers per-instruction exception flags and interrupt requests, then prioritises them.
- Kills the committing instruction and issues one-cycle exception/ERET commands to CP0 (valid, code, BD, EPC, BadVAddr, eret).
- Produces the pipeline flush and the fetch redirect target.

Parameters:
- VEC_BEV1, 32'hBFC00380, exception vector when Status.BEV=1
- VEC_BEV0, 32'h80000180, exception vector when Status.BEV=0
- DRAIN_CYCLES, 2, cycles after a taken event during which new events are ignored; range 1..7

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  1  a real instruction is in MEM
- m_stall  in  1  MEM cannot commit this cycle
- m_pc  in  32  PC of the MEM instruction
- m_bd  in  1  MEM instruction is in a branch delay slot
- m_adel_if  in  1  fetch address error
- m_ri  in  1  reserved instruction
- m_sys  in  1  syscall
- m_bp  in  1  break
- m_ov  in  1  integer overflow
- m_adel_d  in  1  load address error
- m_ades_d  in  1  store address error
- m_daddr  in  32  data virtual address
- m_eret  in  1  MEM instruction is ERET
- int_req  in  1  CP0 unmasked-interrupt response
- cp0_status  in  32  CP0 Status
- cp0_epc  in  32  CP0 EPC
- commit_kill  out  1  combinational; MEM instruction must not write back or store
- exc_valid  out  1  to CP0, one-cycle pulse
- exc_excode  out  5  to CP0
- exc_bd  out  1  to CP0
- exc_epc  out  32  to CP0
- exc_badvaddr  out  32  to CP0
- exc_eret  out  1  to CP0
- flush  out  1  one-cycle pulse; flush IF..MEM
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  fetch target

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; int_pend=0; drain counter=0. A reset asserted in any state aborts the drain, and any pulse pending for the next cycle is discarded.
- int_pend register:
  - set when int_req=1;
  - cleared when int_req=0 or when an interrupt is taken.
  - Level semantics: int_pend follows int_req with one cycle of lag.
- A cycle is eligible when all hold: state IDLE, m_valid=1, m_stall=0.
- hit = eligible AND (int_pend OR any exception flag OR m_eret).
- commit_kill = hit, combinational in that same cycle N. A non-eligible cycle gives commit_kill=0.
- Priority, highest first: Int(0x00), AdEL fetch(0x04), RI(0x0a), Sys(0x08), Bp(0x09), Ov(0x0c), AdEL data(0x04), AdES data(0x05), ERET.
- Any exception pre-empts ERET.
- Registered outputs in cycle N+1, valid for exactly one cycle:
  - exc_valid=1.
  - exc_excode = the winning code; 0 for ERET.
  - exc_bd = m_bd.
  - exc_epc = m_bd ? m_pc-4 : m_pc, with 32-bit wrap (e.g. 0x00000000 gives 0xFFFFFFFC).
  - exc_badvaddr = m_pc for AdEL fetch, m_daddr for AdEL/AdES data, 0 otherwise.
  - exc_eret=1 only when ERET wins.
  - flush=1 and redirect_valid=1.
  - redirect_pc = cp0_epc (sampled in cycle N) when ERET wins; otherwise the vector selected by cp0_status[22] sampled in cycle N.
- Interrupt with a delay slot: interrupt taken on a BD instruction gives epc=m_pc-4 and exc_bd=1.
- Exceptions are not suppressed when Status.EXL=1; CP0 itself blocks the EPC/Cause update.
- FSM:
  - IDLE --hit--> PULSE.
  - PULSE (outputs asserted, one cycle) --> DRAIN with counter=DRAIN_CYCLES-1.
  - DRAIN: decrement each cycle; leave for IDLE when the counter reaches 0.
  - m_valid is ignored in PULSE and DRAIN, and commit_kill stays 0 there.
- m_stall=1 while in IDLE: no action; int_pend keeps following int_req.
- Flags present with m_valid=0 are ignored.

Decomposition:
- Add to the shared header:
  - EXC_Int/AdEL/AdES/Sys/Bp/RI/Ov code macros (the existing EXC_AdEL/EXC_AdES plus new ones);
  - Status_Bev bit index (22).
- Natural sub-module: exc_prio_enc. It is combinational; it maps the flag vector plus int_pend to {hit, excode, is_eret, badvaddr_sel}.
- The FSM, output registers and int_pend stay in exc_ctrl.

Test Plan:
- m_ov=1, m_pc=0x80001000, m_bd=0, BEV=0 -> commit_kill same cycle; next cycle exc_valid=1, excode=0x0c, epc=0x80001000, flush=1, redirect_pc=0x80000180.
- m_adel_d=1, m_daddr=0x00400003, m_bd=1, m_pc=0xBFC00104, BEV=1 -> excode=0x04, bd=1, epc=0xBFC00100, badvaddr=0x00400003, redirect 0xBFC00380.
- m_eret=1 with cp0_epc=0x80002000 -> exc_valid=1, exc_eret=1, excode=0, redirect_pc=0x80002000. Repeat with m_ri=1 also set -> excode=0x0a, exc_eret=0.
- int_req high one cycle earlier plus m_sys=1 -> excode=0x00. Drop int_req, wait for int_pend to clear, present again -> excode=0x08.
- Two consecutive hits with DRAIN_CYCLES=2 -> the second is ignored (no commit_kill) until IDLE is reached. m_stall=1 with m_ov=1 -> nothing happens until m_stall falls.
- Assert reset in the DRAIN state -> all outputs 0 next cycle; FSM in IDLE; an immediately following hit is accepted.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception initiator: exception codes,
// the Status.BEV bit position, FSM state and BadVAddr source encodings.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int unsigned STATUS_BEV = 22;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StDrain
  } exc_state_e;

  typedef enum logic [1:0] {
    BvaNone,
    BvaPc,
    BvaDaddr
  } bva_sel_e;

  // Per-instruction exception flags in priority order (interrupt excluded).
  typedef struct packed {
    logic adel_if;
    logic ri;
    logic sys;
    logic bp;
    logic ov;
    logic adel_d;
    logic ades_d;
  } exc_flags_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle between the MEM stage / CP0 and the exception initiator.
// master: pipeline + CP0 side, slave: exc_ctrl.
interface exc_ctrl_if;
  logic        m_valid;
  logic        m_stall;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_adel_if;
  logic        m_ri;
  logic        m_sys;
  logic        m_bp;
  logic        m_ov;
  logic        m_adel_d;
  logic        m_ades_d;
  logic [31:0] m_daddr;
  logic        m_eret;
  logic        int_req;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;

  logic        commit_kill;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output m_valid, m_stall, m_pc, m_bd, m_adel_if, m_ri, m_sys, m_bp, m_ov,
           m_adel_d, m_ades_d, m_daddr, m_eret, int_req, cp0_status, cp0_epc,
    input  commit_kill, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
           exc_eret, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  m_valid, m_stall, m_pc, m_bd, m_adel_if, m_ri, m_sys, m_bp, m_ov,
           m_adel_d, m_ades_d, m_daddr, m_eret, int_req, cp0_status, cp0_epc,
    output commit_kill, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
           exc_eret, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the winning event among the pending
// interrupt, the instruction's exception flags and ERET.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  exc_flags_t  flags_i,
  input  logic        int_pend_i,
  input  logic        eret_i,
  output logic        hit_o,
  output logic [4:0]  excode_o,
  output logic        is_eret_o,
  output logic        is_int_o,
  output bva_sel_e    bva_sel_o
);

  // Highest priority first; ERET only wins when nothing else is pending.
  always_comb begin
    hit_o     = 1'b1;
    excode_o  = EXC_INT;
    is_eret_o = 1'b0;
    is_int_o  = 1'b0;
    bva_sel_o = BvaNone;
    if (int_pend_i) begin
      is_int_o = 1'b1;
    end else if (flags_i.adel_if) begin
      excode_o  = EXC_ADEL;
      bva_sel_o = BvaPc;
    end else if (flags_i.ri) begin
      excode_o = EXC_RI;
    end else if (flags_i.sys) begin
      excode_o = EXC_SYS;
    end else if (flags_i.bp) begin
      excode_o = EXC_BP;
    end else if (flags_i.ov) begin
      excode_o = EXC_OV;
    end else if (flags_i.adel_d) begin
      excode_o  = EXC_ADEL;
      bva_sel_o = BvaDaddr;
    end else if (flags_i.ades_d) begin
      excode_o  = EXC_ADES;
      bva_sel_o = BvaDaddr;
    end else if (eret_i) begin
      is_eret_o = 1'b1;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt initiator. Kills the committing instruction on
// an event, then issues a one-cycle command to CP0 together with the pipeline
// flush and fetch redirect, and ignores further events while the pipe drains.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV1     = 32'hBFC00380,
  parameter logic [31:0] VEC_BEV0     = 32'h80000180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);

  localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);

  exc_state_e  state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic        int_pend_q, int_pend_d;
  logic        valid_q, valid_d;
  logic [4:0]  excode_q, excode_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;
  logic [31:0] rpc_q, rpc_d;
  logic        eret_q, eret_d;

  exc_flags_t  flags;
  logic        evt;
  logic [4:0]  evt_code;
  logic        evt_eret;
  logic        evt_int;
  bva_sel_e    evt_bva;
  logic        eligible;
  logic        hit;
  logic        unused_status;

  assign flags = {bus.m_adel_if, bus.m_ri, bus.m_sys, bus.m_bp, bus.m_ov,
                  bus.m_adel_d, bus.m_ades_d};

  exc_prio_enc u_prio (
    .flags_i    (flags),
    .int_pend_i (int_pend_q),
    .eret_i     (bus.m_eret),
    .hit_o      (evt),
    .excode_o   (evt_code),
    .is_eret_o  (evt_eret),
    .is_int_o   (evt_int),
    .bva_sel_o  (evt_bva)
  );

  assign eligible = (state_q == StIdle) & bus.m_valid & ~bus.m_stall;
  assign hit      = eligible & evt;

  assign bus.commit_kill = hit;

  // Only Status.BEV matters here.
  assign unused_status = ^{bus.cp0_status[31:STATUS_BEV+1], bus.cp0_status[STATUS_BEV-1:0]};

  // FSM next state: one pulse cycle, then drain until the counter runs out.
  // The drain exits on the cycle its counter decrements to zero.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (hit) state_d = StPulse;
      end
      StPulse: begin
        state_d = StDrain;
        drain_d = DrainInit;
      end
      StDrain: begin
        if (drain_q <= 3'd1) begin
          state_d = StIdle;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command contents for the next cycle; everything reads zero outside the pulse.
  always_comb begin
    valid_d    = 1'b0;
    excode_d   = '0;
    bd_d       = 1'b0;
    epc_d      = '0;
    bva_d      = '0;
    rpc_d      = '0;
    eret_d     = 1'b0;
    int_pend_d = bus.int_req & ~(hit & evt_int);
    if (hit) begin
      valid_d  = 1'b1;
      excode_d = evt_eret ? 5'h00 : evt_code;
      bd_d     = bus.m_bd;
      epc_d    = bus.m_bd ? bus.m_pc - 32'd4 : bus.m_pc;
      eret_d   = evt_eret;
      case (evt_bva)
        BvaPc:    bva_d = bus.m_pc;
        BvaDaddr: bva_d = bus.m_daddr;
        default:  bva_d = '0;
      endcase
      if (evt_eret) begin
        rpc_d = bus.cp0_epc;
      end else begin
        rpc_d = bus.cp0_status[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0;
      end
    end
  end

  // State, interrupt latch and command registers; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      drain_q    <= '0;
      int_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      excode_q   <= '0;
      bd_q       <= 1'b0;
      epc_q      <= '0;
      bva_q      <= '0;
      rpc_q      <= '0;
      eret_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      int_pend_q <= int_pend_d;
      valid_q    <= valid_d;
      excode_q   <= excode_d;
      bd_q       <= bd_d;
      epc_q      <= epc_d;
      bva_q      <= bva_d;
      rpc_q      <= rpc_d;
      eret_q     <= eret_d;
    end
  end

  assign bus.exc_valid      = valid_q;
  assign bus.exc_excode     = excode_q;
  assign bus.exc_bd         = bd_q;
  assign bus.exc_epc        = epc_q;
  assign bus.exc_badvaddr   = bva_q;
  assign bus.exc_eret       = eret_q;
  assign bus.flush          = valid_q;
  assign bus.redirect_valid = valid_q;
  assign bus.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the event rules.
module tb_exc_ctrl;

  localparam int DC  = 2;
  localparam int IGN = (DC < 2) ? 2 : DC;  // cycles after a taken event that are ignored

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_ctrl_if bus_if ();

  exc_ctrl #(
    .VEC_BEV1     (32'hBFC00380),
    .VEC_BEV0     (32'h80000180),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state.
  bit          model_ok = 1'b0;
  bit          mp_int = 1'b0;
  int          busy = 0;
  logic        e_valid = 1'b0;
  logic [4:0]  e_code = '0;
  logic        e_bd = 1'b0;
  logic [31:0] e_epc = '0;
  logic [31:0] e_bva = '0;
  logic [31:0] e_rpc = '0;
  logic        e_eret = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    bus_if.m_valid    = 1'b0;
    bus_if.m_stall    = 1'b0;
    bus_if.m_pc       = '0;
    bus_if.m_bd       = 1'b0;
    bus_if.m_adel_if  = 1'b0;
    bus_if.m_ri       = 1'b0;
    bus_if.m_sys      = 1'b0;
    bus_if.m_bp       = 1'b0;
    bus_if.m_ov       = 1'b0;
    bus_if.m_adel_d   = 1'b0;
    bus_if.m_ades_d   = 1'b0;
    bus_if.m_daddr    = '0;
    bus_if.m_eret     = 1'b0;
    bus_if.int_req    = 1'b0;
    bus_if.cp0_status = '0;
    bus_if.cp0_epc    = '0;
  endtask

  // Compare the current cycle against the model, advance the model, and move to
  // the next negedge. Inputs must already be set for this cycle.
  task automatic cycle();
    bit   f[8];
    int   codes[8] = '{0, 4, 10, 8, 9, 12, 4, 5};
    int   w;
    bit   elig;
    bit   hit;
    #1;
    f[0] = mp_int;
    f[1] = bus_if.m_adel_if;
    f[2] = bus_if.m_ri;
    f[3] = bus_if.m_sys;
    f[4] = bus_if.m_bp;
    f[5] = bus_if.m_ov;
    f[6] = bus_if.m_adel_d;
    f[7] = bus_if.m_ades_d;
    w = -1;
    for (int i = 7; i >= 0; i--) if (f[i]) w = i;
    elig = (busy == 0) && bus_if.m_valid && !bus_if.m_stall;
    hit  = elig && ((w >= 0) || bus_if.m_eret);

    if (!reset) chk("commit_kill", bus_if.commit_kill, hit);
    if (model_ok) begin
      chk("exc_valid", bus_if.exc_valid, e_valid);
      chk("exc_excode", bus_if.exc_excode, e_code);
      chk("exc_bd", bus_if.exc_bd, e_bd);
      chk("exc_epc", bus_if.exc_epc, e_epc);
      chk("exc_badvaddr", bus_if.exc_badvaddr, e_bva);
      chk("exc_eret", bus_if.exc_eret, e_eret);
      chk("flush", bus_if.flush, e_valid);
      chk("redirect_valid", bus_if.redirect_valid, e_valid);
      chk("redirect_pc", bus_if.redirect_pc, e_rpc);
    end

    if (reset || !hit) begin
      e_valid = 0; e_code = 0; e_bd = 0; e_epc = 0; e_bva = 0; e_rpc = 0; e_eret = 0;
    end else begin
      e_valid = 1;
      e_eret  = (w < 0);
      e_code  = (w >= 0) ? 5'(codes[w]) : 5'd0;
      e_bd    = bus_if.m_bd;
      e_epc   = bus_if.m_bd ? bus_if.m_pc - 32'd4 : bus_if.m_pc;
      e_bva   = (w == 1) ? bus_if.m_pc : ((w == 6 || w == 7) ? bus_if.m_daddr : 32'd0);
      if (e_eret) e_rpc = bus_if.cp0_epc;
      else e_rpc = bus_if.cp0_status[22] ? 32'hBFC00380 : 32'h80000180;
    end

    if (reset) begin
      mp_int   = 0;
      busy     = 0;
      model_ok = 1;
    end else begin
      mp_int = bus_if.int_req && !(hit && w == 0);
      if (hit) busy = IGN;
      else if (busy > 0) busy = busy - 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    idle_in();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_valid", bus_if.exc_valid, 0);
    chk("rst_flush", bus_if.flush, 0);
    chk("rst_rpc", bus_if.redirect_pc, 0);
    settle(1);

    // Overflow, BEV=0.
    bus_if.m_valid = 1; bus_if.m_ov = 1; bus_if.m_pc = 32'h80001000;
    #1 chk("ov_kill", bus_if.commit_kill, 1);
    cycle();
    chk("ov_valid", bus_if.exc_valid, 1);
    chk("ov_code", bus_if.exc_excode, 32'h0c);
    chk("ov_epc", bus_if.exc_epc, 32'h80001000);
    chk("ov_flush", bus_if.flush, 1);
    chk("ov_rpc", bus_if.redirect_pc, 32'h80000180);
    settle(3);

    // Data load address error in a delay slot, BEV=1.
    bus_if.m_valid = 1; bus_if.m_adel_d = 1; bus_if.m_daddr = 32'h00400003;
    bus_if.m_bd = 1; bus_if.m_pc = 32'hBFC00104; bus_if.cp0_status = 32'h00400000;
    cycle();
    chk("adel_code", bus_if.exc_excode, 32'h04);
    chk("adel_bd", bus_if.exc_bd, 1);
    chk("adel_epc", bus_if.exc_epc, 32'hBFC00100);
    chk("adel_bva", bus_if.exc_badvaddr, 32'h00400003);
    chk("adel_rpc", bus_if.redirect_pc, 32'hBFC00380);
    settle(3);

    // ERET alone, then ERET pre-empted by RI.
    bus_if.m_valid = 1; bus_if.m_eret = 1; bus_if.cp0_epc = 32'h80002000;
    cycle();
    chk("eret_valid", bus_if.exc_valid, 1);
    chk("eret_eret", bus_if.exc_eret, 1);
    chk("eret_code", bus_if.exc_excode, 0);
    chk("eret_rpc", bus_if.redirect_pc, 32'h80002000);
    settle(3);
    bus_if.m_valid = 1; bus_if.m_eret = 1; bus_if.m_ri = 1; bus_if.cp0_epc = 32'h80002000;
    cycle();
    chk("ri_code", bus_if.exc_excode, 32'h0a);
    chk("ri_eret", bus_if.exc_eret, 0);
    settle(3);

    // Interrupt beats syscall; once int_pend has cleared, syscall is taken.
    bus_if.int_req = 1;
    cycle();
    bus_if.m_valid = 1; bus_if.m_sys = 1; bus_if.m_pc = 32'h80003000;
    cycle();
    chk("int_code", bus_if.exc_excode, 0);
    chk("int_valid", bus_if.exc_valid, 1);
    settle(3);
    bus_if.m_valid = 1; bus_if.m_sys = 1; bus_if.m_pc = 32'h80003000;
    cycle();
    chk("sys_code", bus_if.exc_excode, 32'h08);
    settle(3);

    // Back-to-back hits: the second is ignored until the drain finishes.
    bus_if.m_valid = 1; bus_if.m_ov = 1; bus_if.m_pc = 32'h80004000;
    #1 chk("b2b_kill0", bus_if.commit_kill, 1);
    cycle();
    #1 chk("b2b_kill1", bus_if.commit_kill, 0);
    cycle();
    #1 chk("b2b_kill2", bus_if.commit_kill, 0);
    cycle();
    #1 chk("b2b_kill3", bus_if.commit_kill, 1);
    cycle();
    settle(3);

    // Stall holds off the event.
    bus_if.m_valid = 1; bus_if.m_ov = 1; bus_if.m_stall = 1;
    #1 chk("stall_kill", bus_if.commit_kill, 0);
    cycle();
    chk("stall_valid", bus_if.exc_valid, 0);
    bus_if.m_stall = 0;
    #1 chk("unstall_kill", bus_if.commit_kill, 1);
    cycle();
    settle(3);

    // EPC wrap on a delay-slot instruction at address 0.
    bus_if.m_valid = 1; bus_if.m_ov = 1; bus_if.m_bd = 1; bus_if.m_pc = 32'h0;
    cycle();
    chk("wrap_epc", bus_if.exc_epc, 32'hFFFFFFFC);
    settle(3);

    // Reset while draining, then an immediate hit is accepted.
    bus_if.m_valid = 1; bus_if.m_ov = 1;
    cycle();
    idle_in();
    cycle();
    reset = 1; bus_if.m_valid = 1; bus_if.m_ov = 1;
    cycle();
    chk("drst_valid", bus_if.exc_valid, 0);
    chk("drst_rvalid", bus_if.redirect_valid, 0);
    reset = 0;
    #1 chk("drst_kill", bus_if.commit_kill, 1);
    cycle();
    chk("drst_hit", bus_if.exc_valid, 1);
    settle(3);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 99) == 0);
      bus_if.m_valid    = ($urandom_range(0, 9) < 7);
      bus_if.m_stall    = ($urandom_range(0, 9) < 2);
      bus_if.m_pc       = $urandom & 32'hFFFFFFFC;
      bus_if.m_bd       = $urandom_range(0, 1);
      bus_if.m_adel_if  = ($urandom_range(0, 19) == 0);
      bus_if.m_ri       = ($urandom_range(0, 19) == 0);
      bus_if.m_sys      = ($urandom_range(0, 19) == 0);
      bus_if.m_bp       = ($urandom_range(0, 19) == 0);
      bus_if.m_ov       = ($urandom_range(0, 19) == 0);
      bus_if.m_adel_d   = ($urandom_range(0, 19) == 0);
      bus_if.m_ades_d   = ($urandom_range(0, 19) == 0);
      bus_if.m_daddr    = $urandom;
      bus_if.m_eret     = ($urandom_range(0, 9) == 0);
      bus_if.int_req    = ($urandom_range(0, 7) == 0);
      bus_if.cp0_status = $urandom;
      bus_if.cp0_epc    = $urandom;
      cycle();
    end
    reset = 0;
    settle(2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
